// File: rtl/unidad_pc_if.sv
//------------------------------------------------------------------------------
// Module : unidad_pc_if
// Desc   : Branch-redirect inputs and fetch/link outputs of the PC unit.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface unidad_pc_if;
  logic        stall;
  logic        branch_take;
  logic        branch_link;
  logic [31:0] branch_pc;
  logic [31:0] offset;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        lr_we;
  logic [31:0] lr_data;

  modport master (
    output stall, branch_take, branch_link, branch_pc, offset,
    input  pc, pc_valid, flush, lr_we, lr_data
  );

  modport slave (
    input  stall, branch_take, branch_link, branch_pc, offset,
    output pc, pc_valid, flush, lr_we, lr_data
  );
endinterface

`default_nettype wire

// File: rtl/unidad_pc.sv
//------------------------------------------------------------------------------
// Module : unidad_pc
// Desc   : PC sequencer with branch redirect, squash window and BL link write.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module unidad_pc #(
  parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  wire          clk,
  input  wire          reset,
  unidad_pc_if.slave   bus
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] c_flush_init = 3'(FLUSH_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_pc_valid;
  logic        r_flush;
  logic        r_lr_we, w_lr_we_nxt;
  logic [31:0] r_lr_data, w_lr_data_nxt;
  logic [31:0] w_off_al;
  logic [31:0] w_sum;
  logic [31:0] w_target;

  // Branch target is relative to the branch address plus 8 (ARM pipeline view).
  assign w_off_al = bus.offset & 32'hFFFF_FFFC;
  assign w_sum    = bus.branch_pc + 32'd8 + w_off_al;
  assign w_target = w_sum & 32'hFFFF_FFFC;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pc_nxt      = r_pc;
    w_lr_we_nxt   = 1'b0;
    w_lr_data_nxt = r_lr_data;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.branch_take) begin
          w_pc_nxt    = w_target;
          w_cnt_nxt   = c_flush_init;
          w_state_nxt = S_FLUSH;
          if (bus.branch_link) begin
            w_lr_we_nxt   = 1'b1;
            w_lr_data_nxt = bus.branch_pc + 32'd4;
          end
        end else if (!bus.stall) begin
          w_pc_nxt = r_pc + 32'd4;
        end
      end
      S_FLUSH: begin
        // Branches seen here come from squashed instructions and are dropped.
        if (!bus.stall) begin
          w_pc_nxt  = r_pc + 32'd4;
          w_cnt_nxt = r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            w_state_nxt = S_RUN;
          end
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_BOOT;
      r_cnt      <= 3'd0;
      r_pc       <= RESET_ADDR;
      r_pc_valid <= 1'b0;
      r_flush    <= 1'b0;
      r_lr_we    <= 1'b0;
      r_lr_data  <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pc       <= w_pc_nxt;
      r_pc_valid <= 1'b1;
      r_flush    <= (w_state_nxt == S_FLUSH);
      r_lr_we    <= w_lr_we_nxt;
      r_lr_data  <= w_lr_data_nxt;
    end
  end

  assign bus.pc       = r_pc;
  assign bus.pc_valid = r_pc_valid;
  assign bus.flush    = r_flush;
  assign bus.lr_we    = r_lr_we;
  assign bus.lr_data  = r_lr_data;

endmodule

`default_nettype wire

// File: tb/tb_unidad_pc.sv
//------------------------------------------------------------------------------
// Module : tb_unidad_pc
// Desc   : Directed plus random stimulus against a behavioural PC-unit model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_unidad_pc;

  localparam int c_flush = 2;

  logic        clk = 1'b0;
  logic        t_rst = 1'b1;
  logic        t_stall = 1'b0;
  logic        t_take = 1'b0;
  logic        t_link = 1'b0;
  logic [31:0] t_bpc = 32'd0;
  logic [31:0] t_off = 32'd0;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Model state: booting flag, remaining squash slots, visible outputs.
  bit          m_booting;
  int          m_left;
  logic [31:0] m_pc;
  logic        m_valid, m_flush, m_lr_we;
  logic [31:0] m_lr_data;

  unidad_pc_if bus0 ();
  unidad_pc_if bus1 ();

  assign bus0.stall       = t_stall;
  assign bus0.branch_take = t_take;
  assign bus0.branch_link = t_link;
  assign bus0.branch_pc   = t_bpc;
  assign bus0.offset      = t_off;
  assign bus1.stall       = t_stall;
  assign bus1.branch_take = t_take;
  assign bus1.branch_link = t_link;
  assign bus1.branch_pc   = t_bpc;
  assign bus1.offset      = t_off;

  unidad_pc #(.RESET_ADDR(32'h0000_0000), .FLUSH_CYCLES(c_flush)) u_dut0 (
    .clk   (clk),
    .reset (t_rst),
    .bus   (bus0.slave)
  );

  unidad_pc #(.RESET_ADDR(32'h0000_0100), .FLUSH_CYCLES(c_flush)) u_dut1 (
    .clk   (clk),
    .reset (t_rst),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rs, st, tk, lk, input logic [31:0] bp, of);
    if (rs) begin
      m_booting = 1'b1; m_left = 0; m_pc = 32'h0;
      m_valid = 1'b0; m_flush = 1'b0; m_lr_we = 1'b0; m_lr_data = 32'h0;
      return;
    end
    m_valid = 1'b1;
    m_lr_we = 1'b0;
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_left > 0) begin
      if (!st) begin
        m_pc   = m_pc + 32'd4;
        m_left = m_left - 1;
      end
    end else if (tk) begin
      m_pc   = (bp + 32'd8 + (of & ~32'd3)) & ~32'd3;
      m_left = c_flush;
      if (lk) begin
        m_lr_we   = 1'b1;
        m_lr_data = bp + 32'd4;
      end
    end else if (!st) begin
      m_pc = m_pc + 32'd4;
    end
    m_flush = (m_left > 0);
  endtask

  task automatic step(input string tag, input logic rs, st, tk, lk,
                      input logic [31:0] bp, of);
    t_rst = rs; t_stall = st; t_take = tk; t_link = lk; t_bpc = bp; t_off = of;
    @(posedge clk);
    model_edge(rs, st, tk, lk, bp, of);
    #1;
    chk({tag, ".pc"},       bus0.pc,               m_pc);
    chk({tag, ".pc_valid"}, 32'(bus0.pc_valid),    32'(m_valid));
    chk({tag, ".flush"},    32'(bus0.flush),       32'(m_flush));
    chk({tag, ".lr_we"},    32'(bus0.lr_we),       32'(m_lr_we));
    chk({tag, ".lr_data"},  bus0.lr_data,          m_lr_data);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    // Reset and boot, with a branch offered in BOOT that must be ignored.
    for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("reset.pc_const", bus0.pc, 32'h0);
    step("boot_br", 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h100);
    chk("boot.pc_const", bus0.pc, 32'h0);
    idle("run1");
    idle("run2");

    // Forward BL from the pc=0x10 slot.
    for (int i = 0; i < 10 && m_pc != 32'h10; i++) idle("seek");
    chk("seek.pc10", bus0.pc, 32'h10);
    step("bl_fwd", 1'b0, 1'b0, 1'b1, 1'b1, 32'h08, 32'h0000_0040);
    chk("bl_fwd.target", bus0.pc, 32'h50);
    chk("bl_fwd.lr", bus0.lr_data, 32'h0C);
    idle("bl_fl2");
    idle("bl_done");
    chk("bl_done.pc", bus0.pc, 32'h58);

    // Stall held in RUN.
    for (int i = 0; i < 3; i++) step("stall_run", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Backward branch with stall, wrapping below zero.
    step("bk_stall", 1'b0, 1'b1, 1'b1, 1'b0, 32'h04, 32'hFFFF_FFF0);
    chk("bk.target", bus0.pc, 32'hFFFF_FFFC);
    idle("bk_wrap");
    chk("bk.wrap", bus0.pc, 32'h0);
    // Branch offered in the second squash cycle is dropped.
    step("fl_ign", 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h40);
    chk("fl_ign.pc", bus0.pc, 32'h4);

    // Stall inside the squash window stretches it by one cycle.
    step("br_st", 1'b0, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h10);
    step("br_st_hold", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("br_st_hold.pc", bus0.pc, 32'h1018);
    idle("br_st_f3");
    idle("br_st_end");

    // Reset while a link write is being presented.
    step("rst_bl", 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 32'h8);
    step("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle("rst_boot");
    idle("rst_run");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic        rs, st, tk, lk;
      logic [31:0] bp, of;
      rs = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 25);
      tk = ($urandom_range(0, 99) < 20);
      lk = $urandom_range(0, 1) == 1;
      bp = $urandom;
      of = $urandom;
      if ($urandom_range(0, 1) == 1) of = {{14{of[17]}}, of[17:0]};
      step("rand", rs, st, tk, lk, bp, of);
    end

    // Alternate reset address instance.
    step("ra_rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("ra.rst_pc", bus1.pc, 32'h100);
    chk("ra.rst_valid", 32'(bus1.pc_valid), 32'h0);
    idle("ra_e0");
    chk("ra.e0_pc", bus1.pc, 32'h100);
    chk("ra.e0_valid", 32'(bus1.pc_valid), 32'h1);
    idle("ra_e1");
    chk("ra.e1_pc", bus1.pc, 32'h104);
    idle("ra_e2");
    chk("ra.e2_pc", bus1.pc, 32'h108);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
